spi_master_sequencer: RTL
=========================

Name: spi_master_sequencer

Overview:
- Upstream front-end for the 4-slave SPI subsystem.
- Queues host words in a TX FIFO and feeds them one at a time to the SPI master's data input, pulsing the master's start.
- Waits for the master's tx/rx done indications, then stores the received word in an RX FIFO for the host.
- Lets software stream multi-word transfers without tracking every master handshake itself.

Parameters:
- BITS_SIZE, 10, word width; matches the SPI master bits_size.
- DEPTH, 8, entries per FIFO; power of two, at least 2.
- TIMEOUT_CYCLES, 1023, WAIT-state cycle limit; used only with SPI_SEQ_TIMEOUT_EN.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- wr_data  in  BITS_SIZE  host word to transmit.
- wr_en  in  1  push wr_data into the TX FIFO.
- full  out  1  TX FIFO holds DEPTH words.
- rd_data  out  BITS_SIZE  head of the RX FIFO (first-word fall-through); 0 when empty.
- rd_en  in  1  pop the RX FIFO.
- empty  out  1  RX FIFO holds no words.
- tx_count  out  $clog2(DEPTH+1)  TX FIFO occupancy.
- rx_count  out  $clog2(DEPTH+1)  RX FIFO occupancy.
- busy  out  1  FSM is not in IDLE.
- overflow  out  1  sticky; a write was attempted while full.
- underflow  out  1  sticky; a read was attempted while empty.
- timeout_err  out  1  sticky; a transfer timed out (SPI_SEQ_TIMEOUT_EN only).
- clr_err  in  1  clears all sticky error flags.
- spi_data_in  out  BITS_SIZE  to the master's data_in; registered.
- spi_tx_start  out  1  to the master's tx_start; one-cycle pulse.
- spi_tx_done  in  1  from the master's tx_done.
- spi_rx_done  in  1  from the master's rx_done.
- spi_data_out  in  BITS_SIZE  from the master's data_out.

Behaviour:
- Reset (async, immediate):
  - FSM goes to IDLE; both FIFOs are emptied.
  - Outputs: spi_data_in=0, spi_tx_start=0, busy=0, counts=0, full=0, empty=1, rd_data=0.
  - All error flags are cleared.
  - Reset mid-transfer abandons the word in flight; nothing is stored in the RX FIFO.
- TX FIFO:
  - wr_en && !full writes on the edge; tx_count increments.
  - wr_en && full drops the word and sets overflow. This holds even if the FSM pops in the same cycle, because full is the registered state.
- RX FIFO:
  - rd_en && !empty pops on the edge.
  - rd_en && empty sets underflow; a same-cycle push is not forwarded to rd_data.
  - A push from STORE and a pop in the same cycle are both honoured; rx_count is unchanged.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Counts saturate at neither end because guards prevent it.
- FSM states: IDLE, LOAD, START, WAIT, STORE.
  - IDLE: move to LOAD when tx_count≠0 and rx_count<DEPTH. If the RX FIFO is full, stay in IDLE (back-pressure; no TX word is consumed).
  - LOAD: register the TX head into spi_data_in, pop the TX FIFO, clear the done flags, go to START.
  - START: spi_tx_start=1 for this cycle only; go to WAIT.
  - WAIT: a high spi_tx_done sets tx_seen; a high spi_rx_done sets rx_seen.
    - Either order or the same cycle is accepted.
    - When both are seen (including the cycle the second arrives), go to STORE.
    - Done inputs are ignored outside WAIT.
  - STORE: push spi_data_out into the RX FIFO, go to IDLE.
- spi_data_in holds its value until the next LOAD.
- Latency:
  - With the FSM idle and the FIFO empty, spi_tx_start is high for one cycle, two edges after the wr_en edge.
  - Back-to-back words: a minimum 4-cycle gap between spi_tx_start pulses, plus the master's transfer time.
- busy=1 in LOAD, START, WAIT and STORE.
- clr_err clears the sticky flags. If an error event occurs in the same cycle, the set wins.

Optional Feature:
- Macro: SPI_SEQ_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT, cleared on WAIT entry.
  - If TIMEOUT_CYCLES cycles elapse without both done flags, set timeout_err and return to IDLE with no RX push.
  - The TX word is consumed (not retried).
- Undefined:
  - No counter is built; timeout_err is tied to 0.
  - WAIT waits indefinitely.

Test Plan:
- Single word: write 0x2A5; master model returns 0x13C after 12 cycles. Expect spi_tx_start pulsed once, spi_data_in=0x2A5, rx_count=1, rd_data=0x13C, busy=0 afterwards.
- Done ordering: check rx_done before tx_done, tx_done before rx_done, and both in the same cycle. Each must yield exactly one RX push; no second spi_tx_start until the word is stored.
- Full/overflow: write 9 words with DEPTH=8 and the master stalled. Expect full=1 after 8, the 9th dropped, overflow=1, tx_count=8. Then clr_err gives overflow=0.
- RX back-pressure: fill the RX FIFO to 8 with the host not reading, queue 2 more TX words. Expect the FSM to stay IDLE, tx_count=2, no spi_tx_start. One rd_en restarts the sequence.
- Reset mid-WAIT: assert reset during WAIT. Expect an immediate busy=0, counts=0, empty=1, spi_tx_start=0; a later done pulse is ignored.
- Timeout (macro defined, TIMEOUT_CYCLES=20): the master never signals done. Expect timeout_err=1 at cycle 20 of WAIT, rx_count=0, and the next queued word starts normally.

Source files
------------

// File: rtl/spi_master_sequencer.sv
// TX/RX FIFO front-end that feeds one word at a time to an SPI master.
// Define SPI_SEQ_TIMEOUT_EN to build the WAIT-state watchdog (timeout_err).
module spi_master_sequencer #(
    parameter int BITS_SIZE      = 10,
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [BITS_SIZE-1:0]         wr_data,
    input  logic                         wr_en,
    output logic                         full,
    output logic [BITS_SIZE-1:0]         rd_data,
    input  logic                         rd_en,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   tx_count,
    output logic [$clog2(DEPTH+1)-1:0]   rx_count,
    output logic                         busy,
    output logic                         overflow,
    output logic                         underflow,
    output logic                         timeout_err,
    input  logic                         clr_err,
    output logic [BITS_SIZE-1:0]         spi_data_in,
    output logic                         spi_tx_start,
    input  logic                         spi_tx_done,
    input  logic                         spi_rx_done,
    input  logic [BITS_SIZE-1:0]         spi_data_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] START = 3'd2;
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] STORE = 3'd4;

    logic [2:0] state;

    logic [BITS_SIZE-1:0] tx_mem [DEPTH];
    logic [BITS_SIZE-1:0] rx_mem [DEPTH];
    logic [AW-1:0] tx_wptr, tx_rptr;
    logic [AW-1:0] rx_wptr, rx_rptr;

    logic tx_seen, rx_seen;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic both_done, timed_out;

    assign full  = (tx_count == FULL_CNT);
    assign empty = (rx_count == '0);
    assign busy  = (state != IDLE);
    assign spi_tx_start = (state == START);
    assign rd_data = empty ? '0 : rx_mem[rx_rptr];

    assign tx_push = wr_en && !full;
    assign tx_pop  = (state == LOAD);
    assign rx_push = (state == STORE);
    assign rx_pop  = rd_en && !empty;

    // The second done may arrive in the very cycle we decide to leave WAIT.
    assign both_done = (tx_seen || spi_tx_done) &&
                       (rx_seen || spi_rx_done);

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] wait_cnt;

    assign timed_out = (state == WAIT) && !both_done &&
                       (wait_cnt == TO_LAST);
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr] <= wr_data;
        if (rx_push) rx_mem[rx_wptr] <= spi_data_out;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
            if (tx_push && !tx_pop)
                tx_count <= tx_count + 1'b1;
            else if (tx_pop && !tx_push)
                tx_count <= tx_count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
            if (rx_push && !rx_pop)
                rx_count <= rx_count + 1'b1;
            else if (rx_pop && !rx_push)
                rx_count <= rx_count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            spi_data_in <= '0;
            tx_seen     <= 1'b0;
            rx_seen     <= 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    // RX full holds the sequencer off without consuming TX
                    if (tx_count != '0 && rx_count != FULL_CNT)
                        state <= LOAD;
                end
                LOAD: begin
                    spi_data_in <= tx_mem[tx_rptr];
                    tx_seen     <= 1'b0;
                    rx_seen     <= 1'b0;
                    state       <= START;
                end
                START: begin
`ifdef SPI_SEQ_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    if (spi_tx_done) tx_seen <= 1'b1;
                    if (spi_rx_done) rx_seen <= 1'b1;
`ifdef SPI_SEQ_TIMEOUT_EN
                    wait_cnt <= wait_cnt + 1'b1;
`endif
                    if (both_done)
                        state <= STORE;
                    else if (timed_out)
                        state <= IDLE;
                end
                STORE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky flags: a new event in the clearing cycle wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (wr_en && full)
                overflow <= 1'b1;
            else if (clr_err)
                overflow <= 1'b0;

            if (rd_en && empty)
                underflow <= 1'b1;
            else if (clr_err)
                underflow <= 1'b0;

            if (timed_out)
                timeout_err <= 1'b1;
            else if (clr_err)
                timeout_err <= 1'b0;
        end
    end

endmodule
